// File: rtl/cpu2core_debug_pkg.sv
// Shared definitions for the OCI debug-memory engine: FSM states, jdo field
// positions and the fixed Avalon byte-enable pattern.
package cpu2core_debug_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      RD_WAIT = 2'd2,
      WR_REQ  = 2'd3
   } ocimem_state_e;

   localparam int JDO_WDATA_LSB = 3;
   localparam int JDO_ADDR_LSB  = 17;
   localparam int JDO_RD        = 34;
   localparam int JDO_ERRCLR    = 36;

   localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/cpu2core_cpu0_cpu_debug_ocimem_engine.sv
// Sysclk-side executor of JTAG debug-memory commands: turns take_* strobes into
// single-word Avalon-MM reads/writes and reports data/status back via MonDReg.
module cpu2core_cpu0_cpu_debug_ocimem_engine
   import cpu2core_debug_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int TIMEOUT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [31:0]       m_writedata,
   output logic [3:0]        m_byteenable,
   input  logic              m_waitrequest,
   input  logic [31:0]       m_readdata,
   input  logic              m_readdatavalid
);

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

   ocimem_state_e       state_q, state_d;
   logic [31:0]         mon_d_q, mon_d_d;
   logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
   logic                ready_q, ready_d;
   logic                error_q, error_d;
   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

   logic cmd_any;
   logic tmo_hit;
   logic unused_jdo;

   assign cmd_any    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign tmo_hit    = (tmo_q == TMO_LAST);
   assign unused_jdo = ^{jdo[37], jdo[35], jdo[2:0]};

   always_comb begin
      state_d = state_q;
      mon_d_d = mon_d_q;
      mon_a_d = mon_a_q;
      error_d = error_q;
      tmo_d   = tmo_q;

      if (state_q == IDLE) begin
         tmo_d = '0;
         if (take_action_ocimem_b) begin
            mon_d_d = jdo[JDO_WDATA_LSB +: 32];
            state_d = WR_REQ;
         end else if (take_action_ocimem_a) begin
            mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_ERRCLR]) begin
               error_d = 1'b0;
            end
            if (jdo[JDO_RD]) begin
               state_d = RD_REQ;
            end
         end else if (take_no_action_ocimem_a) begin
            state_d = RD_REQ;
         end
      end else begin
         tmo_d = tmo_q + TIMEOUT_W'(1);
         // A new command cannot be queued behind a busy transfer; flag it instead.
         if (cmd_any) begin
            error_d = 1'b1;
         end
         unique case (state_q)
            RD_REQ: begin
               if (!m_waitrequest && m_readdatavalid) begin
                  mon_d_d = m_readdata;
                  mon_a_d = mon_a_q + ADDR_W'(1);
                  state_d = IDLE;
               end else if (tmo_hit) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end else if (!m_waitrequest) begin
                  state_d = RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (m_readdatavalid) begin
                  mon_d_d = m_readdata;
                  mon_a_d = mon_a_q + ADDR_W'(1);
                  state_d = IDLE;
               end else if (tmo_hit) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
            WR_REQ: begin
               if (!m_waitrequest) begin
                  mon_a_d = mon_a_q + ADDR_W'(1);
                  state_d = IDLE;
               end else if (tmo_hit) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mon_d_q <= '0;
         mon_a_q <= '0;
         ready_q <= 1'b1;
         error_q <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         mon_d_q <= mon_d_d;
         mon_a_q <= mon_a_d;
         ready_q <= ready_d;
         error_q <= error_d;
         tmo_q   <= tmo_d;
      end
   end

   assign MonDReg       = mon_d_q;
   assign MonAReg       = mon_a_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;
   assign m_address     = mon_a_q;
   assign m_read        = (state_q == RD_REQ);
   assign m_write       = (state_q == WR_REQ);
   assign m_writedata   = mon_d_q;
   assign m_byteenable  = BYTEEN_ALL;

endmodule

// File: tb/tb_cpu2core_cpu0_cpu_debug_ocimem_engine.sv
// Directed bench for the OCI debug-memory engine with a small Avalon slave
// whose stall and read-data timing the stimulus controls.
module tb_cpu2core_cpu0_cpu_debug_ocimem_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        takeA, takeNa, takeB;
   logic [31:0] MonDReg;
   logic [7:0]  MonAReg;
   logic        monitorReady, monitorError;
   logic [7:0]  mAddress;
   logic        mRead, mWrite;
   logic [31:0] mWritedata;
   logic [3:0]  mByteenable;
   logic        mWaitrequest;
   logic [31:0] mReaddata;
   logic        mReaddatavalid;

   logic        holdRdv;
   logic        rdvQ;
   logic        pendRd;
   int          wrCount;
   logic [7:0]  wrAddr;
   logic [31:0] wrData;

   int checks = 0;
   int errors = 0;

   cpu2core_cpu0_cpu_debug_ocimem_engine #(.ADDR_W(8), .TIMEOUT_W(8)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (takeA),
      .take_no_action_ocimem_a (takeNa),
      .take_action_ocimem_b    (takeB),
      .MonDReg                 (MonDReg),
      .MonAReg                 (MonAReg),
      .monitor_ready           (monitorReady),
      .monitor_error           (monitorError),
      .m_address               (mAddress),
      .m_read                  (mRead),
      .m_write                 (mWrite),
      .m_writedata             (mWritedata),
      .m_byteenable            (mByteenable),
      .m_waitrequest           (mWaitrequest),
      .m_readdata              (mReaddata),
      .m_readdatavalid         (mReaddatavalid)
   );

   always #5 clk = ~clk;

   // Slave: read data returns one cycle after acceptance unless held back by holdRdv.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rdvQ   <= 1'b0;
         pendRd <= 1'b0;
      end else begin
         rdvQ <= 1'b0;
         if (mRead && !mWaitrequest) begin
            if (holdRdv) pendRd <= 1'b1;
            else         rdvQ   <= 1'b1;
         end else if (pendRd && !holdRdv) begin
            rdvQ   <= 1'b1;
            pendRd <= 1'b0;
         end
      end
   end

   // Record every write the slave accepts.
   initial wrCount = 0;
   always @(posedge clk) begin
      if (mWrite && !mWaitrequest) begin
         wrCount <= wrCount + 1;
         wrAddr  <= mAddress;
         wrData  <= mWritedata;
      end
   end

   assign mReaddatavalid = rdvQ;

   // Compare one observed value against its expectation and count the result.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Pulse one command strobe for a single cycle; kind 0=action_a, 1=no_action_a, 2=action_b.
   task automatic applyStimulus(input int kind, input logic [37:0] jdoVal);
      @(negedge clk);
      jdo    = jdoVal;
      takeA  = (kind == 0);
      takeNa = (kind == 1);
      takeB  = (kind == 2);
      @(negedge clk);
      takeA  = 1'b0;
      takeNa = 1'b0;
      takeB  = 1'b0;
      jdo    = '0;
   endtask

   // Count negedges from the strobe until monitor_ready returns, with a bound.
   task automatic waitReady(output int cycles);
      cycles = 1;
      while (!monitorReady && cycles < 600) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   function automatic logic [37:0] mkA(input logic [7:0] addr, input logic rd, input logic clr);
      logic [37:0] v;
      v = '0;
      v[24:17] = addr;
      v[34]    = rd;
      v[36]    = clr;
      return v;
   endfunction

   function automatic logic [37:0] mkB(input logic [31:0] data);
      logic [37:0] v;
      v = '0;
      v[34:3] = data;
      return v;
   endfunction

   initial begin
      int lat;
      int busy;
      int wrBefore;

      reset        = 1'b1;
      jdo          = '0;
      takeA        = 1'b0;
      takeNa       = 1'b0;
      takeB        = 1'b0;
      mWaitrequest = 1'b0;
      mReaddata    = '0;
      holdRdv      = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      checkOutput("rst_mondreg", MonDReg, 32'h0);
      checkOutput("rst_monareg", {24'h0, MonAReg}, 32'h0);
      checkOutput("rst_ready", {31'h0, monitorReady}, 32'h1);
      checkOutput("rst_error", {31'h0, monitorError}, 32'h0);
      checkOutput("rst_rw", {30'h0, mRead, mWrite}, 32'h0);
      checkOutput("byteenable", {28'h0, mByteenable}, 32'hF);

      // Basic read through action_a with the read bit set.
      mReaddata = 32'hCAFEF00D;
      applyStimulus(0, mkA(8'h10, 1'b1, 1'b0));
      checkOutput("rd_req_addr", {23'h0, mRead, mAddress}, {23'h0, 1'b1, 8'h10});
      waitReady(lat);
      checkOutput("rd_latency", lat, 32'd3);
      checkOutput("rd_data", MonDReg, 32'hCAFEF00D);
      checkOutput("rd_addr_inc", {24'h0, MonAReg}, 32'h11);
      checkOutput("rd_error", {31'h0, monitorError}, 32'h0);

      // Address load without read, then a write at the top address.
      applyStimulus(0, mkA(8'hFF, 1'b0, 1'b0));
      checkOutput("ld_ready", {31'h0, monitorReady}, 32'h1);
      checkOutput("ld_addr", {24'h0, MonAReg}, 32'hFF);
      wrBefore = wrCount;
      applyStimulus(2, mkB(32'h12345678));
      checkOutput("wr_strobe", {31'h0, mWrite}, 32'h1);
      waitReady(lat);
      checkOutput("wr_latency", lat, 32'd2);
      @(negedge clk);
      checkOutput("wr_count", wrCount - wrBefore, 32'd1);
      checkOutput("wr_bus_addr", {24'h0, wrAddr}, 32'hFF);
      checkOutput("wr_bus_data", wrData, 32'h12345678);
      checkOutput("wr_addr_wrap", {24'h0, MonAReg}, 32'h00);
      checkOutput("wr_mondreg", MonDReg, 32'h12345678);

      // Read stalled by waitrequest for several cycles.
      mReaddata    = 32'hA5A55A5A;
      mWaitrequest = 1'b1;
      applyStimulus(0, mkA(8'h20, 1'b1, 1'b0));
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_hold", {23'h0, mRead, mAddress}, {23'h0, 1'b1, 8'h20});
         if (i < 4) @(negedge clk);
      end
      mWaitrequest = 1'b0;
      waitReady(lat);
      checkOutput("stall_ready", {31'h0, monitorReady}, 32'h1);
      checkOutput("stall_data", MonDReg, 32'hA5A55A5A);
      checkOutput("stall_addr", {24'h0, MonAReg}, 32'h21);
      checkOutput("stall_error", {31'h0, monitorError}, 32'h0);

      // Slave never accepts: the engine must abort after 255 busy cycles.
      mWaitrequest = 1'b1;
      applyStimulus(1, '0);
      busy = 0;
      while (mRead === 1'b1 && busy < 1000) begin
         busy++;
         @(negedge clk);
      end
      checkOutput("tmo_cycles", busy, 32'd255);
      checkOutput("tmo_error", {31'h0, monitorError}, 32'h1);
      checkOutput("tmo_ready", {31'h0, monitorReady}, 32'h1);
      checkOutput("tmo_rw", {30'h0, mRead, mWrite}, 32'h0);
      checkOutput("tmo_addr", {24'h0, MonAReg}, 32'h21);
      checkOutput("tmo_data", MonDReg, 32'hA5A55A5A);
      mWaitrequest = 1'b0;
      applyStimulus(0, mkA(8'h30, 1'b0, 1'b1));
      checkOutput("tmo_errclr", {31'h0, monitorError}, 32'h0);

      // A strobe arriving while the read is waiting for data is rejected.
      mReaddata = 32'h0BADBEEF;
      holdRdv   = 1'b1;
      applyStimulus(0, mkA(8'h40, 1'b1, 1'b0));
      applyStimulus(1, '0);
      checkOutput("busy_error", {31'h0, monitorError}, 32'h1);
      checkOutput("busy_ready", {31'h0, monitorReady}, 32'h0);
      checkOutput("busy_addr", {24'h0, MonAReg}, 32'h40);
      holdRdv = 1'b0;
      waitReady(lat);
      checkOutput("busy_done", {31'h0, monitorReady}, 32'h1);
      checkOutput("busy_data", MonDReg, 32'h0BADBEEF);
      checkOutput("busy_addr_inc", {24'h0, MonAReg}, 32'h41);
      @(negedge clk);
      checkOutput("busy_no_rerun", {31'h0, mRead}, 32'h0);
      applyStimulus(0, mkA(8'h55, 1'b0, 1'b1));
      checkOutput("clr_error", {31'h0, monitorError}, 32'h0);
      checkOutput("clr_addr", {24'h0, MonAReg}, 32'h55);
      checkOutput("clr_ready", {31'h0, monitorReady}, 32'h1);

      // Asynchronous reset while a write is stalled.
      mWaitrequest = 1'b1;
      wrBefore     = wrCount;
      applyStimulus(2, mkB(32'hDEADBEEF));
      checkOutput("pre_rst_write", {31'h0, mWrite}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_write", {31'h0, mWrite}, 32'h0);
      checkOutput("arst_mondreg", MonDReg, 32'h0);
      checkOutput("arst_monareg", {24'h0, MonAReg}, 32'h0);
      checkOutput("arst_ready", {31'h0, monitorReady}, 32'h1);
      checkOutput("arst_error", {31'h0, monitorError}, 32'h0);
      @(negedge clk);
      reset        = 1'b0;
      mWaitrequest = 1'b0;
      checkOutput("arst_no_write", wrCount - wrBefore, 32'd0);
      mReaddata = 32'h13579BDF;
      applyStimulus(0, mkA(8'h07, 1'b1, 1'b0));
      waitReady(lat);
      checkOutput("post_rst_latency", lat, 32'd3);
      checkOutput("post_rst_data", MonDReg, 32'h13579BDF);
      checkOutput("post_rst_addr", {24'h0, MonAReg}, 32'h08);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
